// File: rtl/instr_exec_reader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_exec_reader
//  Description : Read-side consumer of the instruction register. Walks a
//                programmed window of entries, captures each instruction,
//                evaluates opcode on operands a/b and presents a signed
//                2*OP_WIDTH result over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_exec_reader #(
    parameter int NUM_ENTRIES = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int OP_WIDTH    = 32,
    parameter int RD_LATENCY  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          start_ptr,
    input  logic [ADDR_WIDTH:0]            count,
    output logic [ADDR_WIDTH-1:0]          read_pointer,
    input  logic [4+2*OP_WIDTH-1:0]        instruction_word,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic signed [2*OP_WIDTH-1:0]   result,
    output logic [3:0]                     res_opcode,
    output logic [ADDR_WIDTH-1:0]          res_ptr,
    output logic                           res_err,
    output logic                           busy,
    output logic                           done
);

    localparam int RES_WIDTH = 2 * OP_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] c_last_ptr  = ADDR_WIDTH'(NUM_ENTRIES - 1);
    localparam logic [ADDR_WIDTH:0]   c_max_count = (ADDR_WIDTH + 1)'(NUM_ENTRIES);
    localparam logic [ADDR_WIDTH:0]   c_one       = (ADDR_WIDTH + 1)'(1);
    localparam logic [2:0]            c_lat_last  = 3'(RD_LATENCY - 1);

    localparam logic [3:0] c_op_zero  = 4'd0;
    localparam logic [3:0] c_op_passa = 4'd1;
    localparam logic [3:0] c_op_passb = 4'd2;
    localparam logic [3:0] c_op_add   = 4'd3;
    localparam logic [3:0] c_op_sub   = 4'd4;
    localparam logic [3:0] c_op_mult  = 4'd5;
    localparam logic [3:0] c_op_div   = 4'd6;
    localparam logic [3:0] c_op_mod   = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t                       r_state;
    logic [ADDR_WIDTH:0]          r_remaining;
    logic [2:0]                   r_lat;
    logic [3:0]                   r_opc;
    logic signed [OP_WIDTH-1:0]   r_op_a;
    logic signed [OP_WIDTH-1:0]   r_op_b;

    logic [ADDR_WIDTH:0]          w_count_clamped;
    logic signed [RES_WIDTH-1:0]  w_a_ext;
    logic signed [RES_WIDTH-1:0]  w_b_ext;
    logic signed [RES_WIDTH-1:0]  w_calc;
    logic                         w_err;

    // Requests beyond the register depth execute the whole register once.
    assign w_count_clamped = (count > c_max_count) ? c_max_count : count;

    // Operands are widened first so MULT/DIV cannot overflow the result.
    assign w_a_ext = $signed({{OP_WIDTH{r_op_a[OP_WIDTH-1]}}, r_op_a});
    assign w_b_ext = $signed({{OP_WIDTH{r_op_b[OP_WIDTH-1]}}, r_op_b});

    // Opcode evaluation on the captured instruction; errors force a zero result.
    always_comb begin
        w_calc = '0;
        w_err  = 1'b0;
        case (r_opc)
            c_op_zero:  w_calc = '0;
            c_op_passa: w_calc = w_a_ext;
            c_op_passb: w_calc = w_b_ext;
            c_op_add:   w_calc = w_a_ext + w_b_ext;
            c_op_sub:   w_calc = w_a_ext - w_b_ext;
            c_op_mult:  w_calc = w_a_ext * w_b_ext;
            c_op_div: begin
                if (r_op_b == '0) begin
                    w_err = 1'b1;
                end else begin
                    w_calc = w_a_ext / w_b_ext;
                end
            end
            c_op_mod: begin
                if (r_op_b == '0) begin
                    w_err = 1'b1;
                end else begin
                    w_calc = w_a_ext % w_b_ext;
                end
            end
            default:    w_err = 1'b1;
        endcase
    end

    // Run sequencer: fetch, execute, hand off result, advance pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_lat        <= '0;
            r_opc        <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            read_pointer <= '0;
            result       <= '0;
            res_opcode   <= '0;
            res_ptr      <= '0;
            res_valid    <= 1'b0;
            res_err      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        read_pointer <= start_ptr;
                        r_remaining  <= w_count_clamped;
                        r_lat        <= '0;
                        busy         <= 1'b1;
                        r_state      <= (w_count_clamped == '0) ? S_FIN : S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Pointer is held stable until the register read has settled.
                    if (r_lat == c_lat_last) begin
                        r_opc   <= instruction_word[4+2*OP_WIDTH-1 -: 4];
                        r_op_a  <= instruction_word[2*OP_WIDTH-1 -: OP_WIDTH];
                        r_op_b  <= instruction_word[OP_WIDTH-1:0];
                        r_lat   <= '0;
                        r_state <= S_EXEC;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                S_EXEC: begin
                    result     <= w_calc;
                    res_err    <= w_err;
                    res_opcode <= r_opc;
                    res_ptr    <= read_pointer;
                    res_valid  <= 1'b1;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    // res_valid is always high here, so ready alone completes it.
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        r_remaining <= r_remaining - c_one;
                        if (r_remaining == c_one) begin
                            r_state <= S_FIN;
                        end else begin
                            read_pointer <= (read_pointer == c_last_ptr) ?
                                            '0 : read_pointer + 1'b1;
                            r_state      <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_exec_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_exec_reader
//  Description : Directed self-checking bench for instr_exec_reader with a
//                combinational instruction register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_exec_reader;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [4:0]         start_ptr;
    logic [5:0]         count;
    logic [4:0]         read_pointer;
    logic [67:0]        instruction_word;
    logic               res_valid;
    logic               res_ready;
    logic signed [63:0] result;
    logic [3:0]         res_opcode;
    logic [4:0]         res_ptr;
    logic               res_err;
    logic               busy;
    logic               done;

    logic [67:0] mem [0:31];

    int tests  = 0;
    int failed = 0;

    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;

    instr_exec_reader #(
        .NUM_ENTRIES(32), .ADDR_WIDTH(5), .OP_WIDTH(32), .RD_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .start_ptr(start_ptr),
        .count(count), .read_pointer(read_pointer),
        .instruction_word(instruction_word), .res_valid(res_valid),
        .res_ready(res_ready), .result(result), .res_opcode(res_opcode),
        .res_ptr(res_ptr), .res_err(res_err), .busy(busy), .done(done)
    );

    function automatic logic [67:0] mk(input logic [3:0] op,
                                       input logic signed [31:0] a,
                                       input logic signed [31:0] b);
        return {op, a, b};
    endfunction

    task automatic do_start(input logic [4:0] sp, input logic [5:0] cnt);
        start = 1'b1; start_ptr = sp; count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (res_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_ptr = '0; count = '0; res_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({res_valid, res_err, busy, done, read_pointer, res_ptr, res_opcode} !== '0) begin
            failed++;
            $display("FAIL reset_ctrl got v=%b e=%b busy=%b done=%b rp=%0d ptr=%0d opc=%0d required all 0",
                     res_valid, res_err, busy, done, read_pointer, res_ptr, res_opcode);
        end
        tests++;
        if (result !== 64'sd0) begin
            failed++; $display("FAIL reset_result got %0d required 0", result);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic signed [63:0] exp_res [3];
        bit ok;
        exp_res = '{64'sd8, -64'sd4, -64'sd28};
        mem[0] = mk(OP_ADD, 5, 3);
        mem[1] = mk(OP_SUB, 5, 9);
        mem[2] = mk(OP_MULT, -4, 7);
        res_ready = 1'b1;
        do_start(5'd0, 6'd3);
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            tests++;
            if (!ok) begin
                failed++; $display("FAIL basic_valid k=%0d got res_valid=0 required 1", k);
            end else begin
                tests++;
                if (result !== exp_res[k]) begin
                    failed++; $display("FAIL basic_result k=%0d got %0d required %0d", k, result, exp_res[k]);
                end
                tests++;
                if (res_ptr !== 5'(k) || busy !== 1'b1 || res_err !== 1'b0) begin
                    failed++; $display("FAIL basic_ptr k=%0d got ptr=%0d busy=%b err=%b required ptr=%0d busy=1 err=0",
                                       k, res_ptr, busy, res_err, k);
                end
            end
            @(negedge clk);
        end
        wait_done(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL basic_done got done=0 required 1"); end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failed++; $display("FAIL basic_done_pulse got done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_wrap();
        logic signed [63:0] exp_res [3];
        logic [4:0]         exp_ptr [3];
        bit ok;
        exp_res = '{64'sd11, 64'sd22, 64'sd0};
        exp_ptr = '{5'd30, 5'd31, 5'd0};
        mem[30] = mk(OP_PASSA, 11, 99);
        mem[31] = mk(OP_PASSB, 77, 22);
        mem[0]  = mk(OP_ZERO, 5, 6);
        res_ready = 1'b1;
        do_start(5'd30, 6'd3);
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            tests++;
            if (!ok || result !== exp_res[k] || res_ptr !== exp_ptr[k]) begin
                failed++; $display("FAIL wrap k=%0d got valid=%b res=%0d ptr=%0d required res=%0d ptr=%0d",
                                   k, ok, result, res_ptr, exp_res[k], exp_ptr[k]);
            end
            @(negedge clk);
        end
        wait_done(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL wrap_done got done=0 required 1"); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        mem[4] = mk(OP_DIV, -7, 2);
        mem[5] = mk(OP_MOD, -7, 2);
        res_ready = 1'b0;
        do_start(5'd4, 6'd2);
        wait_valid(ok);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (res_valid !== 1'b1 || result !== -64'sd3 || res_ptr !== 5'd4 || res_opcode !== OP_DIV) begin
                failed++; $display("FAIL bp_hold cyc=%0d got v=%b res=%0d ptr=%0d opc=%0d required 1 -3 4 6",
                                   i, res_valid, result, res_ptr, res_opcode);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (res_valid !== 1'b0) begin
            failed++; $display("FAIL bp_transfer got res_valid=%b required 0", res_valid);
        end
        wait_valid(ok);
        tests++;
        if (!ok || result !== -64'sd1 || res_ptr !== 5'd5) begin
            failed++; $display("FAIL bp_mod got valid=%b res=%0d ptr=%0d required res=-1 ptr=5", ok, result, res_ptr);
        end
        @(negedge clk);
        wait_done(ok);
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic signed [63:0] exp_res [4];
        logic               exp_err [4];
        bit ok;
        exp_res = '{64'sd0, 64'sd0, 64'sh4000_0000_0000_0000, 64'sd2147483648};
        exp_err = '{1'b1, 1'b1, 1'b0, 1'b0};
        mem[8]  = mk(OP_DIV, 9, 0);
        mem[9]  = mk(4'd12, 1, 2);
        mem[10] = mk(OP_MULT, 32'sh8000_0000, 32'sh8000_0000);
        mem[11] = mk(OP_DIV, 32'sh8000_0000, -1);
        res_ready = 1'b1;
        do_start(5'd8, 6'd4);
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            tests++;
            if (!ok || result !== exp_res[k] || res_err !== exp_err[k]) begin
                failed++; $display("FAIL err k=%0d got valid=%b res=%0d err=%b required res=%0d err=%b",
                                   k, ok, result, res_err, exp_res[k], exp_err[k]);
            end
            @(negedge clk);
        end
        wait_done(ok);
        @(negedge clk);
    endtask

    task automatic test_count_zero();
        res_ready = 1'b1;
        do_start(5'd17, 6'd0);
        tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failed++; $display("FAIL zero_c1 got done=%b busy=%b required 0 1", done, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || read_pointer !== 5'd17) begin
            failed++; $display("FAIL zero_c2 got done=%b busy=%b v=%b rp=%0d required 1 0 0 17",
                               done, busy, res_valid, read_pointer);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin failed++; $display("FAIL zero_c3 got done=%b required 0", done); end
    endtask

    task automatic test_ignore_start();
        int n = 0;
        bit seen = 1'b0;
        for (int i = 12; i < 16; i++) mem[i] = mk(OP_ADD, 32'(i), 1);
        res_ready = 1'b1;
        do_start(5'd12, 6'd4);
        for (int i = 0; i < 200; i++) begin
            if (i == 4) begin start = 1'b1; start_ptr = 5'd0; count = 6'd1; end
            if (i == 5) start = 1'b0;
            if (res_valid) n++;
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        tests++;
        if (!seen || n != 4 || read_pointer !== 5'd15) begin
            failed++; $display("FAIL ignore_start got done=%b results=%0d rp=%0d required 1 4 15", seen, n, read_pointer);
        end
        @(negedge clk);
    endtask

    task automatic test_clamp();
        int n = 0;
        bit seen = 1'b0;
        res_ready = 1'b1;
        do_start(5'd0, 6'd40);
        for (int i = 0; i < 400; i++) begin
            if (res_valid) n++;
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        tests++;
        if (!seen || n != 32) begin
            failed++; $display("FAIL clamp got done=%b results=%0d required 1 32", seen, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int dones = 0;
        mem[0] = mk(OP_ADD, 5, 3);
        mem[1] = mk(OP_SUB, 5, 9);
        res_ready = 1'b0;
        do_start(5'd0, 6'd3);
        wait_valid(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL rst_pre got res_valid=0 required 1"); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({res_valid, res_err, busy, done, read_pointer, res_ptr, res_opcode} !== '0 || result !== 64'sd0) begin
            failed++; $display("FAIL rst_mid got v=%b busy=%b done=%b rp=%0d ptr=%0d res=%0d required all 0",
                               res_valid, busy, done, read_pointer, res_ptr, result);
        end
        for (int i = 0; i < 5; i++) begin
            if (done || res_valid || busy) dones++;
            @(negedge clk);
        end
        tests++;
        if (dones != 0) begin failed++; $display("FAIL rst_idle got %0d active cycles required 0", dones); end
        res_ready = 1'b1;
        do_start(5'd1, 6'd1);
        wait_valid(ok);
        tests++;
        if (!ok || result !== -64'sd4 || res_ptr !== 5'd1) begin
            failed++; $display("FAIL rst_restart got valid=%b res=%0d ptr=%0d required -4 1", ok, result, res_ptr);
        end
        @(negedge clk);
        wait_done(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL rst_restart_done got done=0 required 1"); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_errors();
        test_count_zero();
        test_ignore_start();
        test_clamp();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
